// File: rtl/optical_rx_deframer_pkg.sv
// Shared definitions for the optical receive deframer: state encoding,
// default framing parameters and the bit-vote helper.
package optical_rx_deframer_pkg;

    localparam int   OVERSAMPLE_DEF = 8;     // sample ticks per line bit
    localparam logic IDLE_LEVEL_DEF = 1'b0;  // line level with the LED off
    localparam int   FRAME_BITS     = 8;     // data bits per frame

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    // Majority of three mid-bit samples; rejects a single-sample glitch.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/optical_rx_deframer_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous photodiode level into the
// system clock domain. Reset value is the idle line level so a reset does
// not look like a start bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the input through two flops; reset is synchronous.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments here make both flops sample their
        // old values on the same edge, giving a real two-stage pipeline.
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/optical_rx_deframer.sv
// Oversampling UART-style deframer for an optical link: finds the start bit,
// majority-votes each data bit at mid-bit, checks the stop bit and hands the
// byte to a valid/ready consumer through a single holding register.
module optical_rx_deframer
    import optical_rx_deframer_pkg::*;
#(
    parameter int   OVERSAMPLE = OVERSAMPLE_DEF,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sample_clk,
    input  logic       rx_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0]       BIDX_LAST  = 3'(FRAME_BITS - 1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bidx_q, bidx_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]            vote_q, vote_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  sample_clk_q;

    logic                  rx_s;
    logic                  tick;
    logic                  good_frame;
    logic [2:0]            vote_now;

    sync_2ff #(
        .RST_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (rx_in),
        .q_o    (rx_s)
    );

    assign tick = sample_clk && !sample_clk_q;

    // Next-state logic for the deframer FSM and the output holding register.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        shreg_d     = shreg_q;
        vote_d      = vote_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        good_frame  = 1'b0;

        // With small OVERSAMPLE the last vote sample lands on the shift tick,
        // so take it straight from the line in that case.
        vote_now = vote_q;
        if (cnt_q == CNT_MID_P1) vote_now[2] = rx_s;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_s != IDLE_LEVEL) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID_M1 && rx_s == IDLE_LEVEL) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        bidx_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_MID_M1) vote_d[0] = rx_s;
                    if (cnt_q == CNT_MID)    vote_d[1] = rx_s;
                    if (cnt_q == CNT_MID_P1) vote_d[2] = rx_s;
                    if (cnt_q == CNT_LAST) begin
                        shreg_d = {maj3(vote_now), shreg_q[FRAME_BITS-1:1]};
                        bidx_d  = bidx_q + 3'd1;
                        cnt_d   = '0;
                        if (bidx_q == BIDX_LAST) state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Decide at mid stop bit and resync early to IDLE.
                    if (cnt_q == CNT_MID) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (rx_s == IDLE_LEVEL) good_frame  = 1'b1;
                        else                    frame_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A new byte takes the holding register only if it is free or
        // being drained this cycle; otherwise it is dropped.
        if (good_frame) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shreg_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: the shift and holding registers are plain flops, not a
            // memory array, so they are reset with the control state and a
            // partial byte can never leak out after reset.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bidx_q       <= '0;
            shreg_q      <= '0;
            vote_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sample_clk_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bidx_q       <= bidx_d;
            shreg_q      <= shreg_d;
            vote_q       <= vote_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            sample_clk_q <= sample_clk;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/optical_rx_deframer.md
OPTICAL_RX_DEFRAMER -- requirements
Module: optical_rx_deframer

Interface
REQ-001 Parameter OVERSAMPLE, default 8: sample ticks per bit; SHALL be even and at least 4.
REQ-002 Parameter IDLE_LEVEL, default 1'b0: line level when the LED is off or idle.
REQ-003 clock  input  1  system clock (27 MHz); all logic SHALL be on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 sample_clk  input  1  divided sample clock, a level signal in the clock domain, from the sample-clock divider.
REQ-006 rx_in  input  1  photodiode comparator output, asynchronous.
REQ-007 out_data  output  8  received byte.
REQ-008 out_valid  output  1  out_data holds an unconsumed byte.
REQ-009 out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit not at IDLE_LEVEL.
REQ-011 overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.

Function
REQ-012 sample_clk SHALL be registered once; tick = sample_clk && !sample_clk_q, a one-cycle pulse on each rising edge of sample_clk.
REQ-013 rx_in SHALL pass through a 2-flop synchroniser (rx_s); rx_s SHALL be examined only on tick cycles.
REQ-014 Frame format: start bit (!IDLE_LEVEL), 8 data bits LSB first, stop bit (IDLE_LEVEL), each bit OVERSAMPLE ticks long.
REQ-015 FSM states are IDLE, START, DATA and STOP; a tick counter cnt runs from 0 to OVERSAMPLE-1 and a bit index bidx runs from 0 to 7.
REQ-016 IDLE: on a tick with rx_s != IDLE_LEVEL, the FSM SHALL go to START with cnt=0.
REQ-017 START: cnt SHALL increment each tick; at cnt==OVERSAMPLE/2-1, if rx_s==IDLE_LEVEL, the FSM SHALL return to IDLE (glitch reject, no pulse).
REQ-018 START: at cnt==OVERSAMPLE-1, the FSM SHALL go to DATA with cnt=0 and bidx=0.
REQ-019 DATA: each bit value SHALL be the majority of rx_s at cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-020 DATA: at cnt==OVERSAMPLE-1, the voted bit SHALL shift into shreg[7] (right shift) and bidx SHALL increment; after bidx==7 the FSM SHALL go to STOP with cnt=0.
REQ-021 STOP: at cnt==OVERSAMPLE/2, if rx_s==IDLE_LEVEL the frame is good, otherwise frame_err SHALL pulse; either way the FSM SHALL go to IDLE on that tick (early resync).
REQ-022 Good frame with out_valid==0, or with out_valid && out_ready in the same cycle: out_data SHALL take shreg and out_valid SHALL be 1 on the next cycle.
REQ-023 Good frame with out_valid && !out_ready: the new byte SHALL be dropped, out_data SHALL be kept, and overrun SHALL pulse.
REQ-024 out_valid && out_ready with no new frame: out_valid SHALL be 0 on the next cycle; out_data SHALL hold its value.
REQ-025 Latency: out_valid SHALL rise exactly 1 clock after the STOP decision tick.
REQ-026 A frame_err frame SHALL NOT alter out_data or out_valid.

Reset
REQ-027 While reset_n==0 at a clock edge, the FSM SHALL go to IDLE and cnt, bidx, shreg, out_data, out_valid, frame_err, overrun and sample_clk_q SHALL become 0; synchroniser flops SHALL become IDLE_LEVEL.
REQ-028 Reset mid-frame SHALL discard the partial byte; the first tick after release SHALL be evaluated in IDLE.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, OVERSAMPLE default, IDLE_LEVEL default and frame bit count (8).
REQ-030 The 2-flop synchroniser SHALL be a sub-module named sync_2ff; all other logic SHALL stay flat.

Verification
REQ-031 Drive sample_clk with period 14 clocks and send byte 8'hA5 at 8 ticks/bit -> out_data=8'hA5, out_valid=1 exactly 1 clock after the stop tick; frame_err=0 and overrun=0.
REQ-032 Send a 2-tick start glitch then idle -> FSM returns to IDLE; no out_valid, frame_err or overrun pulse.
REQ-033 Send 8'h3C with the stop bit forced to !IDLE_LEVEL -> one frame_err pulse; out_valid stays 0.
REQ-034 Send 8'h11 then 8'h22 with out_ready=0 -> out_data=8'h11 and one overrun pulse; raising out_ready clears out_valid next cycle.
REQ-035 Hold out_ready=1 while frame 8'h5A completes -> back-to-back bytes 8'h5A then 8'hC3 are both delivered; out_valid is 1 for one cycle each.
REQ-036 Assert reset_n=0 at data bit 4 of 8'hFF, then send 8'h0F -> only 8'h0F is delivered.
